ifu_prefetch: RTL and testbench



---
 rtl/ifu_prefetch.sv | 147 ++++++++++++++
 tb/tb_ifu_prefetch.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_prefetch.sv
// Instruction fetch unit: owns the PC, issues word fetches over req/gnt/rvalid,
// buffers returned words with their PCs in an in-order queue for decode, and
// flushes/discards stale traffic on redirects from execute.
module ifu_prefetch #(
    parameter int unsigned          CPU_WIDTH = 32,
    parameter logic [CPU_WIDTH-1:0] RESET_PC  = '0,
    parameter int unsigned          DEPTH     = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic                 imem_req,
    output logic [CPU_WIDTH-1:0] imem_addr,
    input  logic                 imem_gnt,
    input  logic                 imem_rvalid,
    input  logic [CPU_WIDTH-1:0] imem_rdata,
    input  logic                 redir_valid,
    input  logic [CPU_WIDTH-1:0] redir_pc,
    output logic                 misalign_err,
    output logic                 inst_valid,
    output logic [CPU_WIDTH-1:0] inst,
    output logic [CPU_WIDTH-1:0] inst_pc,
    input  logic                 inst_ready
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SUM_W = CNT_W + 1;
    localparam logic [CPU_WIDTH-1:0] NOP     = CPU_WIDTH'(32'h0000_0013);
    localparam logic [CPU_WIDTH-1:0] PC_STEP = CPU_WIDTH'(4);

    typedef enum logic {BOOT, RUN} state_t;

    state_t               state;
    state_t               state_next;
    logic [CPU_WIDTH-1:0] fetch_pc;
    logic [CPU_WIDTH-1:0] resp_pc;
    logic [CPU_WIDTH-1:0] redir_aligned;
    logic [CNT_W-1:0]     q_count;
    logic [CNT_W-1:0]     outstanding;
    logic [CNT_W-1:0]     outstanding_next;
    logic [CNT_W-1:0]     discard_cnt;
    logic [PTR_W-1:0]     rd_ptr;
    logic [PTR_W-1:0]     wr_ptr;
    logic [CPU_WIDTH-1:0] q_inst [DEPTH];
    logic [CPU_WIDTH-1:0] q_pc   [DEPTH];
    logic                 fire;
    logic                 rsp;
    logic                 push;
    logic                 pop;

    assign imem_addr        = fetch_pc;
    assign fire             = imem_req && imem_gnt;
    // A response with nothing outstanding (e.g. left over from before reset) is ignored
    assign rsp              = imem_rvalid && (outstanding != '0);
    assign push             = rsp && (discard_cnt == '0) && !redir_valid;
    assign inst_valid       = (q_count != '0);
    assign pop              = inst_valid && inst_ready;
    assign inst             = inst_valid ? q_inst[rd_ptr] : NOP;
    assign inst_pc          = inst_valid ? q_pc[rd_ptr] : '0;
    assign redir_aligned    = {redir_pc[CPU_WIDTH-1:2], 2'b00};
    assign outstanding_next = outstanding + CNT_W'(fire) - CNT_W'(rsp);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    // Next state and credit-limited fetch request
    always_comb begin
        state_next = state;
        imem_req   = 1'b0;
        case (state)
            BOOT: state_next = RUN;
            RUN: imem_req = ((SUM_W'(q_count) + SUM_W'(outstanding)) < SUM_W'(DEPTH))
                            && !redir_valid;
            default: state_next = BOOT;
        endcase
    end

    // Fetch/response PCs, in-flight tracking and stale-response discard count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc     <= RESET_PC;
            resp_pc      <= RESET_PC;
            outstanding  <= '0;
            discard_cnt  <= '0;
            misalign_err <= 1'b0;
        end else begin
            misalign_err <= redir_valid && (redir_pc[1:0] != 2'b00);
            outstanding  <= outstanding_next;
            if (redir_valid) begin
                fetch_pc    <= redir_aligned;
                resp_pc     <= redir_aligned;
                discard_cnt <= outstanding_next;
            end else begin
                if (fire) begin
                    fetch_pc <= fetch_pc + PC_STEP;
                end
                if (rsp) begin
                    if (discard_cnt != '0) begin
                        discard_cnt <= discard_cnt - CNT_W'(1);
                    end else begin
                        resp_pc <= resp_pc + PC_STEP;
                    end
                end
            end
        end
    end

    // Queue pointers and occupancy; a redirect empties the queue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            q_count <= '0;
        end else if (redir_valid) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            q_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            q_count <= q_count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Queue storage; contents only matter while counted as occupied
    always_ff @(posedge clk) begin
        if (push) begin
            q_inst[wr_ptr] <= imem_rdata;
            q_pc[wr_ptr]   <= resp_pc;
        end
    end

    // The credit rule must keep the queue from overflowing
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
                                    !(push && (q_count == CNT_W'(DEPTH))));

endmodule

// File: tb/tb_ifu_prefetch.sv
// Self-checking bench for ifu_prefetch: directed stimulus, a small in-order
// memory responder, and a scoreboard checked by an independent monitor.
module tb_ifu_prefetch;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic        misalign_err;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;

    int total = 0;
    int bad   = 0;

    int cyc       = 0;
    int mem_lat   = 1;
    int gnt_count = 0;
    int gnt_limit = 0;
    int spur_req  = 0;
    int spur_done = 0;

    exp_t        exp_q [$];
    pend_t       pend  [$];
    logic [31:0] glog  [$];

    always #5 clk = ~clk;

    // Grants are metered so each test fetches a bounded, known set of words
    assign imem_gnt = (gnt_count < gnt_limit);

    ifu_prefetch #(.CPU_WIDTH(32), .RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_gnt     (imem_gnt),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .redir_valid  (redir_valid),
        .redir_pc     (redir_pc),
        .misalign_err (misalign_err),
        .inst_valid   (inst_valid),
        .inst         (inst),
        .inst_pc      (inst_pc),
        .inst_ready   (inst_ready)
    );

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_inst(input logic [31:0] pc);
        exp_q.push_back('{pc: pc, data: word(pc)});
    endtask

    // Memory: records grants on the edge, answers in order after mem_lat cycles
    initial begin
        logic        fire_s;
        logic [31:0] addr_s;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        forever begin
            @(posedge clk);
            cyc++;
            fire_s = rst_n && imem_req && imem_gnt;
            addr_s = imem_addr;
            #1;
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
            if (!rst_n) begin
                pend.delete();
                glog.delete();
                gnt_count = 0;
            end else begin
                if (fire_s) begin
                    pend.push_back('{addr: addr_s, due: cyc + mem_lat});
                    glog.push_back(addr_s);
                    gnt_count++;
                end
                if (spur_req != spur_done) begin
                    spur_done   = spur_req;
                    imem_rvalid = 1'b1;
                    imem_rdata  = 32'hDEAD_BEEF;
                end else if (pend.size() != 0 && pend[0].due <= cyc + 1) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = word(pend[0].addr);
                    void'(pend.pop_front());
                end
            end
        end
    end

    // Monitor: every instruction decode consumes must be the next expected one
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && inst_valid && inst_ready) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_pc", inst_pc, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_pc", inst_pc, e.pc);
                    check("sb_inst", inst, e.data);
                end
            end
        end
    end

    task automatic restart(input int limit, input int lat, input logic rdy);
        rst_n       = 1'b0;
        redir_valid = 1'b0;
        redir_pc    = '0;
        inst_ready  = rdy;
        gnt_limit   = limit;
        mem_lat     = lat;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic check_boot(input string name);
        @(negedge clk);
        check({name, "_boot_req"}, 32'(imem_req), 32'd0);
        @(negedge clk);
        check({name, "_run_req"}, 32'(imem_req), 32'd1);
        check({name, "_run_addr"}, imem_addr, 32'h0000_0000);
    endtask

    task automatic redirect(input logic [31:0] pc);
        redir_valid = 1'b1;
        redir_pc    = pc;
        @(posedge clk);
        #1;
        redir_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] t1_addr [4];
        int          n;
        t1_addr = '{32'h0, 32'h4, 32'h8, 32'hC};
        rst_n       = 1'b1;
        redir_valid = 1'b0;
        redir_pc    = '0;
        inst_ready  = 1'b0;
        #2;
        rst_n = 1'b0;

        // Reset values
        @(negedge clk);
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_addr", imem_addr, 32'h0000_0000);
        check("rst_valid", 32'(inst_valid), 32'd0);
        check("rst_inst", inst, 32'h0000_0013);
        check("rst_pc", inst_pc, 32'h0000_0000);
        check("rst_misalign", 32'(misalign_err), 32'd0);

        // 1: straight-line fetch, zero-wait memory
        @(posedge clk);
        #1;
        expect_inst(32'h0);
        expect_inst(32'h4);
        expect_inst(32'h8);
        expect_inst(32'hC);
        restart(4, 1, 1'b1);
        check_boot("t1");
        drain("t1_drain");
        check("t1_ngnt", 32'(glog.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < glog.size()) check("t1_addr", glog[i], t1_addr[i]);
        end

        // 2: backpressure holds occupancy plus outstanding at DEPTH
        expect_inst(32'h0);
        expect_inst(32'h4);
        expect_inst(32'h8);
        restart(3, 1, 1'b0);
        repeat (10) @(negedge clk);
        check("t2_ngnt", 32'(glog.size()), 32'd2);
        check("t2_req_off", 32'(imem_req), 32'd0);
        check("t2_head_valid", 32'(inst_valid), 32'd1);
        check("t2_head_pc", inst_pc, 32'h0);
        @(posedge clk);
        #1;
        inst_ready = 1'b1;
        drain("t2_drain");

        // 3: redirect with two slow requests in flight
        expect_inst(32'h100);
        expect_inst(32'h104);
        restart(4, 3, 1'b1);
        n = 0;
        while (glog.size() < 2 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t3_two_out", 32'(glog.size()), 32'd2);
        @(posedge clk);
        #1;
        redirect(32'h100);
        drain("t3_drain");

        // 4: redirect coinciding with rvalid and a pop
        expect_inst(32'h0);
        expect_inst(32'h300);
        restart(3, 1, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        redir_valid = 1'b1;
        redir_pc    = 32'h300;
        @(negedge clk);
        check("t4_pre_valid", 32'(inst_valid), 32'd1);
        @(posedge clk);
        #1;
        redir_valid = 1'b0;
        @(negedge clk);
        check("t4_flushed", 32'(inst_valid), 32'd0);
        drain("t4_drain");

        // 5: misaligned redirect target
        expect_inst(32'h200);
        restart(1, 1, 1'b1);
        @(posedge clk);
        #1;
        redirect(32'h203);
        @(negedge clk);
        check("t5_misalign_hi", 32'(misalign_err), 32'd1);
        check("t5_addr", imem_addr, 32'h200);
        check("t5_req", 32'(imem_req), 32'd1);
        @(negedge clk);
        check("t5_misalign_lo", 32'(misalign_err), 32'd0);
        drain("t5_drain");

        // 6: reset mid-request, stray response, then PC wrap
        restart(0, 1, 1'b1);
        spur_req++;
        check_boot("t6a");
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_rst_req", 32'(imem_req), 32'd0);
        check("t6_rst_valid", 32'(inst_valid), 32'd0);
        check("t6_rst_addr", imem_addr, 32'h0);
        expect_inst(32'hFFFF_FFFC);
        expect_inst(32'h0000_0000);
        restart(0, 1, 1'b1);
        check_boot("t6b");
        @(posedge clk);
        #1;
        gnt_limit = 2;
        redirect(32'hFFFF_FFFC);
        drain("t6_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
